shared_reg_arbiter: RTL and testbench

- Round-robin write arbiter that shares one 32-bit CE-gated register (e.g. the LED/score/display register) between NREQ requesters, such as the CPU store path and game-logic FSMs.
- Sequences each write as a 3-state transaction: pick winner, pulse the register's CE with the captured data, acknowledge the winner.
- Sits between the requesters and the register's CE/D inputs; the register itself stays external.

---
 rtl/shared_reg_pkg.sv | 11 +
 rtl/rr_pick.sv | 25 ++
 rtl/shared_reg_arbiter.sv | 80 ++++++++
 tb/tb_shared_reg_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: FSM state type, default sizes and width helper for shared_reg_arbiter.
package shared_reg_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2} state_t;
    localparam int DEF_NREQ = 4;
    localparam int DEF_DW = 32;
    function automatic int clog2_min1(input int n);
        int r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, searches ptr, ptr+1, ... mod NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  idx
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;
    // Rotate so bit 0 is the requester at ptr; the first set bit is then the offset from ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NREQ-1:0];
    always_comb begin
        valid = |rot;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = IDW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (IDW + 1)'(NREQ)) ? IDW'(sum - (IDW + 1)'(NREQ)) : IDW'(sum);
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter driving one CE-gated shared register.
// Define SHARED_REG_LOCK_EN to add the lock port for burst writes by the current winner.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW = DEF_DW,
    parameter int IDW = clog2_min1(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [NREQ-1:0]  lock,
`endif
    output logic [NREQ-1:0]  ack,
    output logic             reg_ce,
    output logic [DW-1:0]    reg_d,
    output logic             busy,
    output logic [IDW-1:0]   gnt_id
);
    state_t          state;
    logic [IDW-1:0]  ptr, idx, nxt;
    logic            valid, hold;
    logic [DW-1:0]   wd [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_wd
        assign wd[i] = wdata[i*DW +: DW];
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .valid(valid),
        .idx  (idx)
    );

    assign nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef SHARED_REG_LOCK_EN
    // Parking the pointer on the holder guarantees it wins the next pick.
    assign hold = lock[gnt_id] & req[gnt_id];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            ack    <= '0;
            reg_ce <= 1'b0;
            reg_d  <= '0;
            busy   <= 1'b0;
            gnt_id <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                IDLE: if (valid) begin
                    reg_d  <= wd[idx];
                    gnt_id <= idx;
                    reg_ce <= 1'b1;
                    busy   <= 1'b1;
                    state  <= WRITE;
                end
                WRITE: begin
                    reg_ce <= 1'b0;
                    ack    <= NREQ'(1) << gnt_id;
                    state  <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    ptr   <= hold ? gnt_id : nxt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: scoreboard plus vector table for shared_reg_arbiter (NREQ=4, DW=32).
module tb_shared_reg_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wd [4];
    logic [127:0] wdata;
    logic [3:0]  ack;
    logic        reg_ce;
    logic [31:0] reg_d;
    logic        busy;
    logic [1:0]  gnt_id;
`ifdef SHARED_REG_LOCK_EN
    logic [3:0]  lock = '0;
`endif

    typedef struct {int id; logic [31:0] data;} exp_t;
    typedef struct {logic [3:0] req; int id;} vec_t;
    exp_t q[$];
    vec_t vt[10];
    int checks = 0, errors = 0, cyc = 0, ack_cnt = 0;
    logic [3:0]  pend = '0;
    logic [31:0] shreg = '0;

    shared_reg_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock  (lock),
`endif
        .ack   (ack),
        .reg_ce(reg_ce),
        .reg_d (reg_d),
        .busy  (busy),
        .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;
    assign wdata = {wd[3], wd[2], wd[1], wd[0]};

    // External shared register loaded through the CE pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_ce) shreg <= reg_d;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst) pend = '0;
        else begin
            if (reg_ce) begin
                if (q.size() == 0) chk("unexpected_ce", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("sb_gnt_id", 32'(gnt_id), e.id);
                    chk("sb_reg_d", reg_d, e.data);
                    pend = 4'(1 << e.id);
                end
            end
            if (ack != 0) begin
                ack_cnt++;
                chk("sb_ack", 32'(ack), 32'(pend));
                pend = '0;
            end
        end
    end

    task automatic wait_ack(output int c);
        int n = 0;
        @(negedge clk);
        while (ack == 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ack_seen", ack != 0, 1);
        c = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, t1;
        logic [31:0] d;
        vt[0] = '{4'b0100, 2}; vt[1] = '{4'b0101, 0}; vt[2] = '{4'b0101, 2};
        vt[3] = '{4'b1000, 3}; vt[4] = '{4'b0011, 0}; vt[5] = '{4'b0011, 1};
        vt[6] = '{4'b1010, 3}; vt[7] = '{4'b0110, 1}; vt[8] = '{4'b1001, 3};
        vt[9] = '{4'b1111, 0};
        foreach (wd[i]) wd[i] = '0;
        req = 4'hf;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ce", reg_ce, 0);
            chk("rst_ack", ack, 0);
            chk("rst_reg_d", reg_d, 0);
            chk("rst_gnt", gnt_id, 0);
            chk("rst_busy", busy, 0);
        end
        req = 0;
        rst = 1;
        wd[2] = 32'hDEADBEEF;
        req = 4'b0100;
        q.push_back('{2, 32'hDEADBEEF});
        @(negedge clk);
        chk("single_ce", reg_ce, 1);
        chk("single_busy1", busy, 1);
        @(negedge clk);
        chk("single_ack", ack, 4'b0100);
        chk("single_ce_off", reg_ce, 0);
        chk("single_busy2", busy, 1);
        req = 0;
        @(negedge clk);
        chk("single_busy_off", busy, 0);
        chk("single_ack_off", ack, 0);
        chk("single_reg", shreg, 32'hDEADBEEF);
        wd[1] = 32'h11110001;
        wd[3] = 32'h33330003;
        req = 4'b1010;
        base = ack_cnt;
        q.push_back('{3, 32'h33330003});
        @(negedge clk);
        chk("midop_ce", reg_ce, 1);
        rst = 0;
        @(negedge clk);
        chk("midop_noack", ack, 0);
        chk("midop_busy", busy, 0);
        chk("midop_reg_d", reg_d, 0);
        chk("midop_gnt", gnt_id, 0);
        rst = 1;
        q.push_back('{1, 32'h11110001});
        @(negedge clk);
        chk("restart_ce", reg_ce, 1);
        @(negedge clk);
        chk("restart_ack", ack, 4'b0010);
        req = 0;
        @(negedge clk);
        chk("midop_ack_count", ack_cnt - base, 1);
        rst = 0;
        @(negedge clk);
        rst = 1;
        foreach (wd[i]) wd[i] = 32'hC0000000 + 32'(i);
        for (int k = 0; k < 5; k++) q.push_back('{k % 4, 32'hC0000000 + 32'(k % 4)});
        req = 4'hf;
        wait_ack(t0);
        for (int k = 1; k < 5; k++) begin
            wait_ack(t1);
            chk("rr_spacing", t1 - t0, 3);
            t0 = t1;
        end
        req = 0;
`ifdef SHARED_REG_LOCK_EN
        @(negedge clk);
        wd[0] = 32'h0B000000;
        wd[1] = 32'h0B000001;
        q.push_back('{1, 32'h0B000001});
        q.push_back('{1, 32'h0B000001});
        q.push_back('{1, 32'h0B000001});
        q.push_back('{0, 32'h0B000000});
        lock = 4'b0010;
        req = 4'b0011;
        wait_ack(t0);
        wait_ack(t0);
        wait_ack(t0);
        lock = 0;
        wait_ack(t0);
        req = 0;
`endif
        @(negedge clk);
        wd[1] = 32'h1;
        req = 4'b0010;
        q.push_back('{1, 32'h1});
        @(negedge clk);
        chk("freeze_ce", reg_ce, 1);
        wd[1] = 32'h2;
        @(negedge clk);
        req = 0;
        chk("freeze_reg_d", reg_d, 32'h1);
        chk("freeze_loaded", shreg, 32'h1);
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            foreach (wd[i]) wd[i] = 32'hA5A50000 + 32'(v * 16 + i);
            d = 32'hA5A50000 + 32'(v * 16 + vt[v].id);
            req = vt[v].req;
            q.push_back('{vt[v].id, d});
            wait_ack(t0);
            req = 0;
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
